// File: rtl/line_fill.sv
// line_fill: fetches one 4-word cache line from RAM with a single read burst
// and returns it to the requester through a valid/ready response.
// Optional feature macro LINE_FILL_HIT_EN: when defined, the last good line is
// kept with a tag-valid bit, and a repeat request for it is answered without a burst.
module line_fill #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int LWIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AWIDTH-1:0]     req_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  inv,
    output logic [AWIDTH-1:0]     line_addr,
    output logic [4*DWIDTH-1:0]   line_data,
    output logic                  line_err,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic [AWIDTH-1:0]     araddr,
    output logic [LWIDTH-1:0]     arlen,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DWIDTH-1:0]     rdata,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic                  rlast
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                r_state;
    logic [1:0]            r_cnt;
    logic [AWIDTH-1:0]     r_araddr;
    logic [LWIDTH-1:0]     r_arlen;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [AWIDTH-1:0]     r_line_addr;
    logic [4*DWIDTH-1:0]   r_line_data;
    logic                  r_line_err;
    logic                  r_line_valid;
    logic                  r_tag_vld;

    logic [AWIDTH-1:0]     w_req_line;
    logic                  w_hit;
    logic                  w_unused;

    assign w_req_line = {req_addr[AWIDTH-1:4], 4'b0000};

`ifdef LINE_FILL_HIT_EN
    // A held line answers the request unless it is being invalidated this cycle.
    assign w_hit    = r_tag_vld && !inv && (w_req_line == r_line_addr);
    assign w_unused = ^req_addr[3:0];
`else
    // Without the held-line feature every request misses and inv has no effect.
    assign w_hit    = 1'b0;
    assign w_unused = ^{req_addr[3:0], inv, r_tag_vld};
`endif

    assign req_ready  = (r_state == IDLE);
    assign araddr     = r_araddr;
    assign arlen      = r_arlen;
    assign arvalid    = r_arvalid;
    assign rready     = r_rready;
    assign line_addr  = r_line_addr;
    assign line_data  = r_line_data;
    assign line_err   = r_line_err;
    assign line_valid = r_line_valid;

    // Fill controller: request capture, address phase, beat collection, response hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 2'd0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_line_addr  <= '0;
            r_line_data  <= '0;
            r_line_err   <= 1'b0;
            r_line_valid <= 1'b0;
            r_tag_vld    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_line_addr <= w_req_line;
                        r_line_err  <= 1'b0;
                        if (w_hit) begin
                            r_line_valid <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            // Words are cleared up front so a short burst leaves zeros,
                            // and the held tag dies because its data is being replaced.
                            r_araddr    <= w_req_line;
                            r_arlen     <= LWIDTH'(3);
                            r_line_data <= '0;
                            r_tag_vld   <= 1'b0;
                            r_state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    // The address register settles one cycle before arvalid rises;
                    // once raised, arvalid holds until the RAM takes it.
                    if (!r_arvalid) begin
                        r_arvalid <= 1'b1;
                    end else if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= 2'd0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        r_line_data[int'(r_cnt)*DWIDTH +: DWIDTH] <= rdata;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            // Fourth beat always completes; rlast here is not required.
                            r_rready     <= 1'b0;
                            r_line_err   <= 1'b0;
                            r_line_valid <= 1'b1;
                            r_tag_vld    <= 1'b1;
                            r_state      <= RESP;
                        end else if (rlast) begin
                            r_rready     <= 1'b0;
                            r_line_err   <= 1'b1;
                            r_line_valid <= 1'b1;
                            r_state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (line_ready) begin
                        r_line_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef LINE_FILL_HIT_EN
            // Invalidate wins over a completion landing in the same cycle.
            if (inv) begin
                r_tag_vld <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_line_fill.sv
// Directed bench for line_fill: table of fills plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_line_fill;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   req_addr;
    logic          req_valid;
    logic          req_ready;
    logic          inv;
    logic [31:0]   line_addr;
    logic [127:0]  line_data;
    logic          line_err;
    logic          line_valid;
    logic          line_ready;
    logic [31:0]   araddr;
    logic [1:0]    arlen;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          rready;
    logic          rlast;

    always #5 clk = ~clk;

    line_fill #(.DWIDTH(32), .AWIDTH(32), .LWIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
        .inv(inv),
        .line_addr(line_addr), .line_data(line_data), .line_err(line_err),
        .line_valid(line_valid), .line_ready(line_ready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] words;     // beat b in bits [b*32 +: 32]
        int           last;      // beat index carrying rlast; 4 = no rlast at all
        int           ar_wait;   // cycles arready is held low
        int           lr_wait;   // cycles line_ready is held low
        logic [31:0]  exp_addr;
        logic [127:0] exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) at negedges for arvalid(0) / rready(1) / line_valid(2).
    task automatic wait_for(input int which, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            case (which)
                0:       ok = arvalid;
                1:       ok = rready;
                default: ok = line_valid;
            endcase
            if (ok) break;
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got timeout expected signal high", name);
        end
    endtask

    // Full transaction driven from a negedge; returns at a negedge in IDLE.
    task automatic run_fill(input int id, input vec_t v);
        bit           ok;
        int           nb;
        logic [127:0] snap;
        chk($sformatf("v%0d req_ready idle", id), req_ready, 1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        @(negedge clk);
        req_valid = (v.lr_wait > 0);
        wait_for(0, $sformatf("v%0d arvalid", id), ok);
        if (!ok) return;
        chk($sformatf("v%0d araddr", id), araddr, v.exp_addr);
        chk($sformatf("v%0d arlen", id), arlen, 3);
        for (int i = 0; i < v.ar_wait; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d arvalid hold", id), arvalid, 1);
            chk($sformatf("v%0d araddr hold", id), araddr, v.exp_addr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk($sformatf("v%0d arvalid drop", id), arvalid, 0);
        chk($sformatf("v%0d rready", id), rready, 1);
        nb = (v.last > 3) ? 4 : v.last + 1;
        for (int b = 0; b < nb; b++) begin
            rvalid = 1'b1;
            rdata  = v.words[b*32 +: 32];
            rlast  = (b == v.last);
            @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
        wait_for(2, $sformatf("v%0d line_valid", id), ok);
        if (!ok) return;
        chk($sformatf("v%0d rready low", id), rready, 0);
        chk($sformatf("v%0d line_addr", id), line_addr, v.exp_addr);
        chk($sformatf("v%0d line_data", id), line_data, v.exp_data);
        chk($sformatf("v%0d line_err", id), line_err, v.exp_err);
        snap = line_data;
        for (int i = 0; i < v.lr_wait; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d lv hold", id), line_valid, 1);
            chk($sformatf("v%0d data hold", id), line_data, snap);
            chk($sformatf("v%0d req_ready busy", id), req_ready, 0);
        end
        line_ready = 1'b1;
        req_valid  = 1'b0;
        @(negedge clk);
        line_ready = 1'b0;
        chk($sformatf("v%0d lv clear", id), line_valid, 0);
        chk($sformatf("v%0d req_ready back", id), req_ready, 1);
    endtask

    initial begin
        bit   ok;
        vec_t v;

        vecs[0] = '{32'h0000_0104, {32'h44, 32'h33, 32'h22, 32'h11}, 3, 0, 0,
                    32'h0000_0100, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0};
        vecs[1] = '{32'h0000_02F8, {32'h0, 32'h0, 32'hBB, 32'hAA}, 1, 0, 0,
                    32'h0000_02F0, {32'h0, 32'h0, 32'hBB, 32'hAA}, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678, 32'hCAFE_0001}, 3, 5, 0,
                    32'hFFFF_FFF0, {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678, 32'hCAFE_0001}, 1'b0};
        vecs[3] = '{32'h0000_0040, {32'h8, 32'h7, 32'h6, 32'h5}, 4, 0, 4,
                    32'h0000_0040, {32'h8, 32'h7, 32'h6, 32'h5}, 1'b0};
        vecs[4] = '{32'h0000_1238, {32'h0, 32'h3, 32'h2, 32'h1}, 2, 0, 0,
                    32'h0000_1230, {32'h0, 32'h3, 32'h2, 32'h1}, 1'b1};

        rst = 1'b1; req_addr = '0; req_valid = 0; inv = 0; line_ready = 0;
        arready = 0; rdata = '0; rvalid = 0; rlast = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst arvalid", arvalid, 0);
        chk("rst rready", rready, 0);
        chk("rst line_valid", line_valid, 0);
        chk("rst line_data", line_data, 0);
        chk("rst araddr", araddr, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst req_ready", req_ready, 1);

        // Table of fills
        for (int i = 0; i < 5; i++) begin
            run_fill(i, vecs[i]);
            @(negedge clk);
        end

        // Minimum latency with arready tied high and rvalid every cycle
        arready = 1'b1; rvalid = 1'b1; rlast = 1'b0; rdata = 32'hFF;
        req_valid = 1'b1; req_addr = 32'h0000_0300;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == 0) chk("lat arvalid e0", arvalid, 0);
            if (k == 1) chk("lat arvalid e1", arvalid, 1);
            if (k == 5) chk("lat lv e5", line_valid, 0);
            if (k == 6) chk("lat lv e6", line_valid, 1);
            rdata = 32'h100 + 32'(k);
        end
        arready = 1'b0; rvalid = 1'b0;
        chk("lat data", line_data, {32'h105, 32'h104, 32'h103, 32'h102});
        chk("lat err", line_err, 0);
        line_ready = 1'b1;
        @(negedge clk);
        line_ready = 1'b0;
        @(negedge clk);

        // Reset during the third beat
        req_valid = 1'b1; req_addr = 32'h0000_0200;
        @(negedge clk);
        req_valid = 1'b0;
        wait_for(0, "rstmid arvalid", ok);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1;
        @(negedge clk);
        rdata = 32'h2;
        @(negedge clk);
        rdata = 32'h3;
        #2 rst = 1'b1;
        #1;
        chk("rstmid rready", rready, 0);
        chk("rstmid line_valid", line_valid, 0);
        chk("rstmid line_data", line_data, 0);
        chk("rstmid araddr", araddr, 0);
        chk("rstmid line_addr", line_addr, 0);
        chk("rstmid arlen", arlen, 0);
        rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        v = '{32'h0000_0200, {32'h4, 32'h3, 32'h2, 32'h1}, 3, 0, 0,
              32'h0000_0200, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0};
        run_fill(10, v);
        @(negedge clk);

        // Repeat request for the line just filled
        run_fill(11, vecs[0]);
        @(negedge clk);
`ifdef LINE_FILL_HIT_EN
        req_valid = 1'b1; req_addr = 32'h0000_0108;
        @(negedge clk);
        req_valid = 1'b0;
        chk("hit line_valid", line_valid, 1);
        chk("hit arvalid", arvalid, 0);
        chk("hit line_data", line_data, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("hit line_err", line_err, 0);
        chk("hit line_addr", line_addr, 32'h0000_0100);
        line_ready = 1'b1;
        @(negedge clk);
        line_ready = 1'b0;
        chk("hit arvalid after", arvalid, 0);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
`else
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
`endif
        v = '{32'h0000_0108, {32'h99, 32'h88, 32'h77, 32'h66}, 3, 0, 0,
              32'h0000_0100, {32'h99, 32'h88, 32'h77, 32'h66}, 1'b0};
        run_fill(12, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/line_fill.md
LINE_FILL -- requirements
Module: line_fill

Interface
REQ-001 SHALL have parameters: DWIDTH, default 32, data word width; AWIDTH, default 32, byte address width; LWIDTH, default 2, burst length field width; line is 4 words (16 bytes), fixed.
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  single clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  req_addr  in  AWIDTH  requested byte address
  req_valid  in  1  fill request
  req_ready  out  1  request accepted when high with req_valid
  inv  in  1  invalidate held line (see Configuration)
  line_addr  out  AWIDTH  line-aligned address of returned line
  line_data  out  4*DWIDTH  word0 in bits [DWIDTH-1:0], word3 in MSBs
  line_err  out  1  burst ended early
  line_valid  out  1  line response valid
  line_ready  in  1  consumer accepts line
  araddr  out  AWIDTH  RAM read burst address
  arlen  out  LWIDTH  RAM burst length minus one
  arvalid  out  1  read address valid
  arready  in  1  RAM accepts address
  rdata  in  DWIDTH  RAM read beat
  rvalid  in  1  beat valid
  rready  out  1  block accepts beat
  rlast  in  1  final beat of burst

Function
REQ-003 SHALL implement states IDLE, ADDR, DATA, RESP; one request in flight at a time.
REQ-004 req_ready SHALL be 1 exactly when state is IDLE; no other output is combinational from inputs.
REQ-005 On req_valid and req_ready in IDLE, SHALL latch req_addr with bits [3:0] cleared into araddr and line_addr, and enter ADDR next cycle.
REQ-006 In ADDR, arvalid SHALL be 1 and arlen SHALL be 3; on arready, SHALL clear arvalid and enter DATA; arvalid SHALL never drop before arready.
REQ-007 In DATA, rready SHALL be 1; each rvalid beat SHALL store rdata into word[cnt] and increment 2-bit cnt (cleared on entry to DATA).
REQ-008 Beat with cnt==3 SHALL complete the fill: enter RESP, line_err=0, rready low next cycle; rlast on that beat is expected and SHALL be ignored if absent.
REQ-009 Beat with rlast=1 and cnt<3 SHALL complete early: enter RESP, line_err=1, unwritten words zero.
REQ-010 rvalid outside DATA SHALL be ignored (rready is 0).
REQ-011 In RESP, line_valid SHALL be 1 with stable line_addr, line_data, line_err; on line_ready, SHALL clear line_valid and return to IDLE.
REQ-012 Minimum latency: request accepted at edge 0, arvalid high after edge 1; with arready immediate and rvalid every cycle, line_valid high after edge 6.
REQ-013 req_valid during non-IDLE states SHALL be ignored; the requester holds it.

Reset
REQ-014 rst SHALL asynchronously force IDLE; outputs SHALL be: req_ready 1 after release, arvalid 0, rready 0, line_valid 0, line_err 0, araddr 0, arlen 0, line_addr 0, line_data 0.
REQ-015 rst mid-burst SHALL discard partial data and the held-line tag; no line response issued.

Configuration
REQ-016 Macro LINE_FILL_HIT_EN: when defined, SHALL hold the last fill's line_addr plus a tag-valid bit, set on a REQ-008 completion with line_err=0.
REQ-017 With LINE_FILL_HIT_EN, an IDLE request whose aligned address matches the valid tag SHALL go directly to RESP next cycle with held data, line_err=0, no RAM burst.
REQ-018 With LINE_FILL_HIT_EN, inv=1 SHALL clear tag-valid; inv in the same cycle as completion SHALL leave tag invalid.
REQ-019 Without LINE_FILL_HIT_EN, inv SHALL be ignored and every request SHALL issue a burst.

Verification
REQ-020 Bench SHALL cover:
  Req 0x0000_0104 -> araddr 0x100, arlen 3; beats 11,22,33,44 (rlast on 4th) -> line_data {44,33,22,11}, line_err 0.
  Hold arready 0 for 5 cycles -> arvalid stays 1, address stable; fill completes after arready.
  rlast on 2nd beat (AA, BB) -> line_data {0,0,BB,AA}, line_err 1.
  line_ready held 0 for 4 cycles -> line_valid and data stable; req_ready 0 throughout.
  rst asserted during 3rd beat -> all outputs 0 immediately, next req performs full burst.
  LINE_FILL_HIT_EN: repeat req 0x108 after fill of 0x100 -> line_valid next cycle, arvalid never 1; after inv, same req issues burst.
